// File: rtl/read_select_mux.sv
// read_select_mux: N:1 readback multiplexer with a single-entry registered
// output and a valid/ready handshake. Requests come from the processor as an
// explicit select, or from an internal round-robin scanner when no manual
// request is present. Out-of-range selects return zero data, set out_err and
// bump a saturating error counter.
module read_select_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int ERR_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      in_ready,
  input  logic                      scan_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_err,
  output logic [ERR_W-1:0]          err_cnt
);

  // One extra bit on the limit so CHANNELS == 2^SEL_W still compares correctly.
  localparam logic [SEL_W:0]   CHAN_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_err_q,   out_err_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic [SEL_W-1:0] scan_ptr_q,  scan_ptr_d;

  logic             req_present;
  logic             req_is_scan;
  logic [SEL_W-1:0] req_sel;
  logic             sel_in_range;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  // Request arbitration: manual select wins over the scanner; accept only
  // when the output register is free or being drained this cycle.
  always_comb begin
    in_ready     = !out_valid_q || out_ready;
    req_present  = in_valid || scan_en;
    req_is_scan  = !in_valid && scan_en;
    req_sel      = in_valid ? in_sel : scan_ptr_q;
    sel_in_range = ({1'b0, req_sel} < CHAN_LIM);
    accept       = req_present && in_ready;
  end

  // Channel data mux; selects with no matching channel yield zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (req_sel == SEL_W'(i)) begin
        sel_data = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output register, error counter and scan pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    scan_ptr_d  = scan_ptr_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_chan_d  = req_sel;
      if (sel_in_range) begin
        out_data_d = sel_data;
        out_err_d  = 1'b0;
      end else begin
        out_data_d = '0;
        out_err_d  = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      if (req_is_scan) begin
        scan_ptr_d = (scan_ptr_q == LAST_CHAN) ? '0 : scan_ptr_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      scan_ptr_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      scan_ptr_q  <= scan_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_read_select_mux.sv
// Testbench for read_select_mux with a 3-channel configuration so that
// select 3 exercises the out-of-range path. Stimulus runs in one process,
// a transaction-level reference model pushes expected results, and a monitor
// on the falling edge compares the DUT against the scoreboard.
module tb_read_select_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int SEL_W    = 2;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CHANNELS*WIDTH-1:0] d = '0;
  logic                      in_valid = 1'b0;
  logic [SEL_W-1:0]          in_sel = '0;
  logic                      in_ready;
  logic                      scan_en = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_err;
  logic [ERR_W-1:0]          err_cnt;

  typedef struct {
    int data;
    int chan;
    int err;
  } result_t;

  result_t expQ[$];
  result_t lastRes = '{0, 0, 0};
  bit      mValid = 1'b0;
  int      mPtr = 0;
  int      mCnt = 0;

  int checks = 0;
  int fails  = 0;

  read_select_mux #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d(d),
    .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .scan_en(scan_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; called at posedge+2 and returns at the next posedge+2.
  task automatic applyStimulus(input bit iv, input int sel, input bit se, input bit ordy);
    in_valid  = iv;
    in_sel    = SEL_W'(sel);
    scan_en   = se;
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic clearModel();
    expQ.delete();
    mValid  = 1'b0;
    mPtr    = 0;
    mCnt    = 0;
    lastRes = '{0, 0, 0};
  endtask

  // Assert reset between clock edges and verify it takes effect immediately.
  task automatic resetMid();
    #1;
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data",  32'(out_data), 0);
    checkOutput("rst_out_chan",  32'(out_chan), 0);
    checkOutput("rst_out_err",   32'(out_err), 0);
    checkOutput("rst_err_cnt",   32'(err_cnt), 0);
    checkOutput("rst_in_ready",  32'(in_ready), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model: one transaction per accepted request, evaluated on the
  // inputs present at the rising edge.
  always @(posedge clk) begin : modelProc
    bit      rdy;
    int      sel;
    result_t r;
    if (rst_n) begin
      rdy = !mValid || out_ready;
      if ((in_valid || scan_en) && rdy) begin
        if (in_valid) begin
          sel = int'(in_sel);
        end else begin
          sel  = mPtr;
          mPtr = (mPtr + 1) % CHANNELS;
        end
        if (sel < CHANNELS) begin
          r.data = int'(d[sel*WIDTH +: WIDTH]);
          r.err  = 0;
        end else begin
          r.data = 0;
          r.err  = 1;
          mCnt   = (mCnt < ERR_MAX) ? mCnt + 1 : ERR_MAX;
        end
        r.chan = sel;
        expQ.push_back(r);
        mValid = 1'b1;
      end else if (out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  // Monitor: compare handshake and held result mid-cycle; pop on drain.
  always @(negedge clk) begin : monitorProc
    result_t e;
    if (rst_n) begin
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("in_ready",  32'(in_ready), 32'(!mValid || out_ready));
      checkOutput("err_cnt",   32'(err_cnt), 32'(mCnt));
      if (mValid) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL scoreboard_empty: got empty queue expected a result at %0t", $time);
        end else begin
          e = expQ[0];
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_chan", 32'(out_chan), 32'(e.chan));
          checkOutput("out_err",  32'(out_err), 32'(e.err));
          if (out_ready) begin
            lastRes = e;
            void'(expQ.pop_front());
          end
        end
      end else begin
        checkOutput("hold_data", 32'(out_data), 32'(lastRes.data));
        checkOutput("hold_chan", 32'(out_chan), 32'(lastRes.chan));
        checkOutput("hold_err",  32'(out_err), 32'(lastRes.err));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic select.
    d = {8'h33, 8'h22, 8'h11};
    applyStimulus(1, 2, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Back-pressure: result stalls, new request blocked, d changes ignored.
    applyStimulus(1, 2, 0, 0);
    d = {8'hA3, 8'hA2, 8'hA1};
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    d = {8'h33, 8'h22, 8'h11};
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Out-of-range selects until the error counter saturates.
    for (int i = 0; i < 300; i++) applyStimulus(1, 3, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("err_cnt_saturated", 32'(err_cnt), ERR_MAX);

    // Scan wrap, then a manual win at pointer 1.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 2, 1, 1);
    applyStimulus(0, 0, 1, 1);

    // Scan freeze at pointer 2, then resume.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);

    // Reset while a result is stalled.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    resetMid();
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      d = CHANNELS*WIDTH'($urandom);
      applyStimulus(($urandom % 3) == 0, int'($urandom % 4), $urandom % 2,
                    ($urandom % 4) != 0);
    end

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
